// File: rtl/gameconsole_pkg.sv
// Shared game-console video types and constants.
// Latency: none (types and constants only).
// Backpressure: none.
package gameconsole_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;

    // One pixel in 8-bit-per-channel form, red in the most significant byte
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // 2x2 ordered-dither thresholds, indexed [y0][x0]
    localparam logic [1:0] BAYER [0:1][0:1] = '{'{2'd0, 2'd2}, '{2'd3, 2'd1}};

endpackage

// File: rtl/vpu_lcd_out_if.sv
// VPU dot stream in, parallel LCD panel bus out.
// Latency: none (wiring only).
// Backpressure: none; the dot strobe is never stalled.
interface vpu_lcd_out_if;

    logic        in_dot;
    logic [31:0] in_color;
    logic        in_hblank;
    logic        in_vblank;
    logic        lcd_dot_en;
    logic        lcd_de;
    logic        lcd_hs_n;
    logic        lcd_vs_n;
    logic [7:0]  lcd_r;
    logic [7:0]  lcd_g;
    logic [7:0]  lcd_b;

    // Video source side: drives the dot stream, observes the panel bus
    modport master (
        output in_dot, in_color, in_hblank, in_vblank,
        input  lcd_dot_en, lcd_de, lcd_hs_n, lcd_vs_n, lcd_r, lcd_g, lcd_b
    );

    // Output stage side: consumes the dot stream, drives the panel bus
    modport slave (
        input  in_dot, in_color, in_hblank, in_vblank,
        output lcd_dot_en, lcd_de, lcd_hs_n, lcd_vs_n, lcd_r, lcd_g, lcd_b
    );

endinterface

// File: rtl/vpu_dither565.sv
// Reduces RGB888 to 565 depth with 2x2 ordered dither, re-expanded to 8 bits.
// Latency: combinational.
// Backpressure: none.
module vpu_dither565
    import gameconsole_pkg::*;
(
    input  rgb888_t pix_in,
    input  logic    x0,
    input  logic    y0,
    output rgb888_t pix_out
);

    logic [1:0] d;
    logic [8:0] r_sum, g_sum, b_sum;
    logic [7:0] r_sat, g_sat, b_sat;

    // Add the threshold (doubled for the 5-bit channels), clamp, truncate, replicate MSBs
    always_comb begin
        pix_out = '0;
        d       = BAYER[y0][x0];
        r_sum   = {1'b0, pix_in.r} + {6'd0, d, 1'b0};
        g_sum   = {1'b0, pix_in.g} + {7'd0, d};
        b_sum   = {1'b0, pix_in.b} + {6'd0, d, 1'b0};
        r_sat   = r_sum[8] ? 8'hFF : r_sum[7:0];
        g_sat   = g_sum[8] ? 8'hFF : g_sum[7:0];
        b_sat   = b_sum[8] ? 8'hFF : b_sum[7:0];
        pix_out.r = {r_sat[7:3], r_sat[7:5]};
        pix_out.g = {g_sat[7:2], g_sat[7:6]};
        pix_out.b = {b_sat[7:3], b_sat[7:5]};
    end

endmodule

// File: rtl/vpu_lcd_out.sv
// Parallel-LCD output stage: DE, active-low syncs, optional dither, frame count, line check.
// Latency: a dot strobed at cycle t appears on the panel bus at t+2.
// Backpressure: none; every strobe is accepted, including back-to-back strobes.
module vpu_lcd_out
    import gameconsole_pkg::*;
#(
    parameter int SCREEN_W = gameconsole_pkg::SCREEN_W,
    parameter int HS_W     = 8,
    parameter int VS_W     = 2,
    parameter int DITHER   = 0
) (
    input  logic                clk,
    input  logic                rst,
    vpu_lcd_out_if.slave        bus,
    input  logic                err_clr,
    output logic [15:0]         frame_cnt,
    output logic                line_err
);

    logic       dot_d1;
    logic       hb, vb, prev_hb, prev_vb;
    rgb888_t    pix, pix_out;
    logic       active, prev_active, hb_rise, vb_rise, de_fall, err_set;
    logic       x0, y0;
    logic [7:0] hcnt, hcnt_nxt;
    logic [3:0] vcnt, vcnt_nxt;
    logic [8:0] act_cnt;
    logic       unused_bits;

    // Alpha byte has no consumer; position parity is unused when dither is off
    assign unused_bits = ^{bus.in_color[31:24], x0, y0};

    // Stage 1: capture the dot; blank history starts "in blank" so reset mid-blank makes no edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dot_d1  <= 1'b0;
            hb      <= 1'b1;
            vb      <= 1'b1;
            prev_hb <= 1'b1;
            prev_vb <= 1'b1;
            pix     <= '0;
        end else begin
            dot_d1 <= bus.in_dot;
            if (bus.in_dot) begin
                pix     <= rgb888_t'(bus.in_color[23:0]);
                hb      <= bus.in_hblank;
                vb      <= bus.in_vblank;
                prev_hb <= hb;
                prev_vb <= vb;
            end
        end
    end

    // Dot-boundary edges and next sync counts; vb_rise takes priority so a shared hb_rise never counts
    always_comb begin
        active      = ~hb & ~vb;
        prev_active = ~prev_hb & ~prev_vb;
        hb_rise     = hb & ~prev_hb;
        vb_rise     = vb & ~prev_vb;
        de_fall     = prev_active & ~active;
        err_set     = dot_d1 & de_fall & (act_cnt != 9'(SCREEN_W));
        hcnt_nxt    = hcnt;
        if (hb_rise)
            hcnt_nxt = 8'(HS_W);
        else if (hcnt != 8'd0)
            hcnt_nxt = hcnt - 8'd1;
        vcnt_nxt = vcnt;
        if (vb_rise)
            vcnt_nxt = 4'(VS_W);
        else if (hb_rise && vcnt != 4'd0)
            vcnt_nxt = vcnt - 4'd1;
    end

    generate
        if (DITHER != 0) begin : g_dither
            vpu_dither565 u_dither (
                .pix_in  (pix),
                .x0      (x0),
                .y0      (y0),
                .pix_out (pix_out)
            );
        end else begin : g_pass
            assign pix_out = pix;
        end
    endgenerate

    // Stage 2: register the panel bus on the delayed strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.lcd_dot_en <= 1'b0;
            bus.lcd_de     <= 1'b0;
            bus.lcd_hs_n   <= 1'b1;
            bus.lcd_vs_n   <= 1'b1;
            bus.lcd_r      <= 8'd0;
            bus.lcd_g      <= 8'd0;
            bus.lcd_b      <= 8'd0;
        end else begin
            bus.lcd_dot_en <= dot_d1;
            if (dot_d1) begin
                bus.lcd_de   <= active;
                bus.lcd_hs_n <= (hcnt_nxt == 8'd0);
                bus.lcd_vs_n <= (vcnt_nxt == 4'd0);
                bus.lcd_r    <= active ? pix_out.r : 8'd0;
                bus.lcd_g    <= active ? pix_out.g : 8'd0;
                bus.lcd_b    <= active ? pix_out.b : 8'd0;
            end
        end
    end

    // Sync counters, position parity, line length and frame counters, advanced once per dot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt      <= 8'd0;
            vcnt      <= 4'd0;
            x0        <= 1'b0;
            y0        <= 1'b0;
            act_cnt   <= 9'd0;
            frame_cnt <= 16'd0;
        end else if (dot_d1) begin
            hcnt <= hcnt_nxt;
            vcnt <= vcnt_nxt;
            // Only the parity of x and y selects a dither threshold
            if (de_fall)
                x0 <= 1'b0;
            else if (active)
                x0 <= ~x0;
            if (vb_rise)
                y0 <= 1'b0;
            else if (de_fall)
                y0 <= ~y0;
            if (de_fall)
                act_cnt <= 9'd0;
            else if (active && act_cnt != 9'd511)
                act_cnt <= act_cnt + 9'd1;
            if (vb_rise)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Sticky line-length error; a new error beats a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            line_err <= 1'b0;
        else if (err_set)
            line_err <= 1'b1;
        else if (err_clr)
            line_err <= 1'b0;
    end

endmodule

// File: tb/tb_vpu_lcd_out.sv
// Bench for vpu_lcd_out: pass-through and dithered instances on one randomized dot stream.
// Latency: expected outputs are due two cycles after each strobe.
// Backpressure: none; strobes are back-to-back or separated by random idle cycles.
`timescale 1ns/1ps
module tb_vpu_lcd_out;
    import gameconsole_pkg::*;

    localparam int HS_W = 8;
    localparam int VS_W = 2;
    localparam int BIG  = 1 << 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_dot = 1'b0;
    logic [31:0] in_color = '0;
    logic        in_hblank = 1'b1;
    logic        in_vblank = 1'b1;
    logic        err_clr = 1'b0;
    logic [15:0] fc0, fc1;
    logic        le0, le1;

    always #5 clk = ~clk;

    vpu_lcd_out_if bus0 ();
    vpu_lcd_out_if bus1 ();
    assign bus0.in_dot    = in_dot;
    assign bus0.in_color  = in_color;
    assign bus0.in_hblank = in_hblank;
    assign bus0.in_vblank = in_vblank;
    assign bus1.in_dot    = in_dot;
    assign bus1.in_color  = in_color;
    assign bus1.in_hblank = in_hblank;
    assign bus1.in_vblank = in_vblank;

    vpu_lcd_out #(.SCREEN_W(SCREEN_W), .HS_W(HS_W), .VS_W(VS_W), .DITHER(0)) u_pass (
        .clk(clk), .rst(rst), .bus(bus0), .err_clr(err_clr), .frame_cnt(fc0), .line_err(le0));
    vpu_lcd_out #(.SCREEN_W(SCREEN_W), .HS_W(HS_W), .VS_W(VS_W), .DITHER(1)) u_dith (
        .clk(clk), .rst(rst), .bus(bus1), .err_clr(err_clr), .frame_cnt(fc1), .line_err(le1));

    typedef struct {
        int          due;
        bit          de, hs_n, vs_n, err_set, vr;
        logic [23:0] c0, c1;
        int          line_id, tag;
    } rec_t;

    rec_t q[$];
    int   cyc = 0;
    int   n_tests = 0, n_fail = 0;
    int   gap_max = 1;
    bit   clr_pending = 1'b0;
    int   cnt_de = 0, cnt_hs = 0, cnt_vs = 0, cnt_both = 0;

    // Model state: distances since events rather than down-counters
    bit m_prev_hb = 1'b1, m_prev_vb = 1'b1;
    int since_hr = BIG, hr_since_vr = BIG, act_in_line = 0, lines_since_vr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [23:0] dith_model(input logic [23:0] c, input int x, input int y);
        int d, r, g, b;
        if (y % 2 == 0) d = (x % 2 == 0) ? 0 : 2;
        else            d = (x % 2 == 0) ? 3 : 1;
        r = int'(c[23:16]) + 2 * d; if (r > 255) r = 255;
        g = int'(c[15:8])  + d;     if (g > 255) g = 255;
        b = int'(c[7:0])   + 2 * d; if (b > 255) b = 255;
        r = r / 8; r = r * 8 + r / 4;
        g = g / 4; g = g * 4 + g / 16;
        b = b / 8; b = b * 8 + b / 4;
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    task automatic model_dot(input bit hb, input bit vb, input logic [23:0] col,
                             input int lid, input int tag);
        bit hr, vr, act, pact, df;
        rec_t r;
        hr   = hb && !m_prev_hb;
        vr   = vb && !m_prev_vb;
        act  = !hb && !vb;
        pact = !m_prev_hb && !m_prev_vb;
        df   = pact && !act;
        if (hr) since_hr = 0; else if (since_hr < BIG) since_hr++;
        if (vr) hr_since_vr = 0; else if (hr && hr_since_vr < BIG) hr_since_vr++;
        r.due     = cyc + 2;
        r.de      = act;
        r.hs_n    = !(since_hr < HS_W);
        r.vs_n    = !(hr_since_vr < VS_W);
        r.c0      = act ? col : 24'd0;
        r.c1      = act ? dith_model(col, act_in_line, lines_since_vr) : 24'd0;
        r.err_set = df && (act_in_line != SCREEN_W);
        r.vr      = vr;
        r.line_id = lid;
        r.tag     = tag;
        if (act) act_in_line++;
        if (df) act_in_line = 0;
        if (vr) lines_since_vr = 0; else if (df) lines_since_vr++;
        m_prev_hb = hb;
        m_prev_vb = vb;
        q.push_back(r);
    endtask

    task automatic cycle(input bit dot, input bit hb, input bit vb, input logic [23:0] col,
                         input int lid, input int tag);
        @(posedge clk); #1;
        in_dot  = dot;
        err_clr = clr_pending;
        clr_pending = 1'b0;
        if (dot) begin
            in_hblank = hb;
            in_vblank = vb;
            in_color  = {8'($urandom_range(0, 255)), col};
            model_dot(hb, vb, col, lid, tag);
        end else begin
            in_hblank = 1'($urandom_range(0, 1));
            in_vblank = 1'($urandom_range(0, 1));
            in_color  = $urandom;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0, 24'd0, 0, 0);
    endtask

    task automatic dot(input bit hb, input bit vb, input logic [23:0] col, input int lid, input int tag);
        int g;
        g = (gap_max == 0) ? 0 : $urandom_range(0, gap_max);
        idle(g);
        cycle(1'b1, hb, vb, col, lid, tag);
    endtask

    // cmode 0: fixed 0x123456; 1: random; 2: dither probe colours on the first two dots
    task automatic line(input int n_act, input int n_blk, input bit vb_a, input bit vb_b,
                        input int cmode, input int lid, input int clr_dot);
        logic [23:0] col;
        int          tag;
        for (int i = 0; i < n_act; i++) begin
            tag = 0;
            col = 24'($urandom);
            if (cmode == 0) begin col = 24'h123456; tag = 3; end
            else if (cmode == 2 && i == 0) begin col = 24'hFFFFFF; tag = 1; end
            else if (cmode == 2 && i == 1) begin col = 24'hF8FCF8; tag = 2; end
            dot(1'b0, vb_a, col, lid, tag);
        end
        for (int i = 0; i < n_blk; i++) begin
            dot(1'b1, vb_b, 24'($urandom), lid, 0);
            if (i == clr_dot) clr_pending = 1'b1;
        end
    endtask

    // Every-cycle comparison of both instances against the model
    initial begin
        bit          e_de, e_hs, e_vs, e_err, clr_prev, en;
        logic [23:0] e_c0, e_c1;
        int          e_fc;
        rec_t        r;
        e_de = 0; e_hs = 1; e_vs = 1; e_err = 0; clr_prev = 0;
        e_c0 = '0; e_c1 = '0; e_fc = 0;
        wait (!rst);
        forever begin
            @(negedge clk);
            en = (q.size() > 0) && (q[0].due == cyc);
            if (en) begin
                r = q.pop_front();
                e_de = r.de; e_hs = r.hs_n; e_vs = r.vs_n; e_c0 = r.c0; e_c1 = r.c1;
                if (r.vr) e_fc = (e_fc + 1) % 65536;
            end
            if (en && r.err_set) e_err = 1'b1;
            else if (clr_prev)   e_err = 1'b0;
            chk("dot_en", bus0.lcd_dot_en, en);
            chk("dot_en_d", bus1.lcd_dot_en, en);
            chk("de", bus0.lcd_de, e_de);
            chk("de_d", bus1.lcd_de, e_de);
            chk("hs_n", bus0.lcd_hs_n, e_hs);
            chk("hs_n_d", bus1.lcd_hs_n, e_hs);
            chk("vs_n", bus0.lcd_vs_n, e_vs);
            chk("vs_n_d", bus1.lcd_vs_n, e_vs);
            chk("rgb", {bus0.lcd_r, bus0.lcd_g, bus0.lcd_b}, e_c0);
            chk("rgb_d", {bus1.lcd_r, bus1.lcd_g, bus1.lcd_b}, e_c1);
            chk("frame_cnt", fc0, e_fc);
            chk("frame_cnt_d", fc1, e_fc);
            chk("line_err", le0, e_err);
            chk("line_err_d", le1, e_err);
            if (en) begin
                if (r.line_id == 1) begin
                    cnt_de += int'(bus0.lcd_de);
                    cnt_hs += int'(!bus0.lcd_hs_n);
                end
                if (r.line_id >= 4 && r.line_id <= 6) cnt_vs += int'(!bus0.lcd_vs_n);
                if (r.line_id == 4 && !bus0.lcd_hs_n && !bus0.lcd_vs_n) cnt_both++;
                if (r.tag == 3) chk("fixed_rgb", {bus0.lcd_r, bus0.lcd_g, bus0.lcd_b}, 24'h123456);
                if (r.tag == 1) chk("dither_sat_0_1", {bus1.lcd_r, bus1.lcd_g, bus1.lcd_b}, 24'hFFFFFF);
                if (r.tag == 2) begin
                    chk("dither_1_1", {bus1.lcd_r, bus1.lcd_g, bus1.lcd_b}, 24'hFFFFFF);
                    chk("pass_1_1", {bus0.lcd_r, bus0.lcd_g, bus0.lcd_b}, 24'hF8FCF8);
                end
            end
            clr_prev = err_clr;
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dot_en", bus0.lcd_dot_en, 0);
        chk("rst_de", bus0.lcd_de, 0);
        chk("rst_hs_n", bus0.lcd_hs_n, 1);
        chk("rst_vs_n", bus0.lcd_vs_n, 1);
        chk("rst_rgb", {bus0.lcd_r, bus0.lcd_g, bus0.lcd_b}, 0);
        chk("rst_frame_cnt", fc0, 0);
        chk("rst_line_err", le0, 0);
        rst = 1'b0;

        // Blank dots already in blank at reset release: no syncs, no frame
        repeat (20) dot(1'b1, 1'b1, 24'($urandom), 0, 0);
        idle(3);
        chk("blank_hs_idle", bus0.lcd_hs_n, 1);
        chk("blank_vs_idle", bus0.lcd_vs_n, 1);
        chk("blank_frame_cnt", fc0, 0);

        gap_max = 0;
        line(320, 80, 1'b0, 1'b0, 0, 1, -1);
        gap_max = 1;
        idle(3);
        chk("good_line_err", le0, 0);
        line(319, 80, 1'b0, 1'b0, 1, 2, -1);
        idle(3);
        chk("short_line_err", le0, 1);
        line(320, 80, 1'b0, 1'b0, 1, 3, 5);
        idle(3);
        chk("cleared_err", le0, 0);
        chk("frame_before_vb", fc0, 0);
        // Last active line ends straight into vblank: hb_rise, vb_rise, de_fall together, clear racing set
        line(318, 80, 1'b0, 1'b1, 1, 4, 0);
        idle(3);
        chk("set_beats_clear", le0, 1);
        chk("first_frame", fc0, 1);
        line(320, 80, 1'b1, 1'b1, 1, 5, -1);
        line(320, 80, 1'b1, 1'b1, 1, 6, -1);
        clr_pending = 1'b1;
        idle(3);
        chk("clear_in_vblank", le0, 0);

        line(320, 80, 1'b0, 1'b0, 1, 7, -1);
        line(320, 80, 1'b0, 1'b0, 2, 8, -1);
        // Vblank begins at the start of a line, without an hb_rise
        line(320, 80, 1'b1, 1'b1, 1, 9, -1);
        line(320, 80, 1'b1, 1'b1, 1, 10, -1);
        idle(3);
        chk("second_frame", fc0, 2);
        chk("frame2_line_err", le0, 0);

        // Short random lines: sync reloads, frequent errors, random blanking and clears
        repeat (40) begin
            gap_max = $urandom_range(0, 2);
            line($urandom_range(0, 12), $urandom_range(1, 12),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 1, 11,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1);
        end
        idle(6);

        chk("all_dots_seen", q.size(), 0);
        chk("line1_de_count", cnt_de, 320);
        chk("line1_hs_low", cnt_hs, HS_W);
        chk("vblank_vs_low", cnt_vs, 800);
        chk("hs_vs_together", cnt_both, HS_W);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
